tff_dff_counter_reg: RTL

//  WIDTH-bit register built only from T flip-flop cells, converted back to D-style behaviour.
//  - D-style load: each cell is driven with t = d ^ q.
//  - Also supports hold, count up and count down, all computed as per-bit toggle masks.
//  - Pairs with the DFF->TFF conversion block; used as a loadable counter in sequential labs.

---
 rtl/tff_dff_pkg.sv | 11 +
 rtl/tff_cell.sv | 19 +
 rtl/tff_dff_counter_reg.sv | 62 ++++++
 3 files changed

// File: rtl/tff_dff_pkg.sv
// rtl/tff_dff_pkg.sv - mode encodings shared by the TFF-based loadable counter
package tff_dff_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_HOLD = 2'b00;
  localparam mode_t MODE_LOAD = 2'b01;
  localparam mode_t MODE_UP   = 2'b10;
  localparam mode_t MODE_DOWN = 2'b11;

endpackage

// File: rtl/tff_cell.sv
// rtl/tff_cell.sv - single T flip-flop with synchronous reset to a per-bit value
module tff_cell (
  input  logic clk,
  input  logic rst,
  input  logic rst_val,
  input  logic t,
  output logic q
);

  // Toggle on t, reset wins over any pending toggle.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= rst_val;
    end else begin
      q <= q ^ t;
    end
  end

endmodule

// File: rtl/tff_dff_counter_reg.sv
// rtl/tff_dff_counter_reg.sv - loadable up/down counter built only from T flip-flop cells
module tff_dff_counter_reg
  import tff_dff_pkg::*;
#(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  mode_t            mode,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             wrap
);

  logic [WIDTH-1:0] t;
  logic [WIDTH-1:0] up_mask;
  logic [WIDTH-1:0] down_mask;

  // Bit i toggles when every lower bit is 1 (up) or 0 (down); bit 0 always toggles.
  assign up_mask[0]   = 1'b1;
  assign down_mask[0] = 1'b1;

  for (genvar i = 1; i < WIDTH; i++) begin : g_mask
    assign up_mask[i]   = &q[i-1:0];
    assign down_mask[i] = ~|q[i-1:0];
  end

  // Select the toggle vector; a D-style load toggles exactly the bits that differ.
  always_comb begin
    t = '0;
    if (en) begin
      case (mode)
        MODE_LOAD: t = d ^ q;
        MODE_UP:   t = up_mask;
        MODE_DOWN: t = down_mask;
        default:   t = '0;
      endcase
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    tff_cell u_cell (
      .clk     (clk),
      .rst     (rst),
      .rst_val (RESET_VAL[i]),
      .t       (t[i]),
      .q       (q[i])
    );
  end

  // Flag the edge on which the counter rolls over in either direction.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrap <= 1'b0;
    end else begin
      wrap <= en && (((mode == MODE_UP) && (&q)) || ((mode == MODE_DOWN) && (~|q)));
    end
  end

endmodule
